// File: rtl/wb_serial_dshot_arbiter.sv
// Wishbone sequencer handing the shared ESC line between the serial and DSHOT engines.
// Optional DSHOT inactivity auto-revert: define SERIAL_DSHOT_ARB_TIMEOUT_EN.
module wb_serial_dshot_arbiter #(
    parameter logic [15:0] GUARD_DEFAULT  = 16'd1000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    input  logic        serial_busy_i,
    input  logic        dshot_busy_i,
    output logic        mux_sel_o,
    output logic        line_oe_o,
    output logic        switching_o
);
    localparam int unsigned GUARD_W = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TO_W    = 24;
    localparam logic [9:0]  ADR_CTRL   = 10'h100;
    localparam logic [9:0]  ADR_STATUS = 10'h101;
    localparam logic [9:0]  ADR_GUARD  = 10'h102;

    typedef enum logic [1:0] {S_SERIAL, S_DSHOT, S_DRAIN, S_GUARD} state_t;

    state_t             state, state_nxt;
    logic [GUARD_W-1:0] cnt, cnt_nxt, guard_cycles;
    logic [CNT_W-1:0]   switch_cnt;
    logic               target, target_nxt, mux_nxt, line_oe_nxt, switching_nxt;
    logic               sw_done, force_clr, force_q, req_sel, revert_q, timeout_hit;
    logic               bus_sel, bus_acc, bus_wr, ctrl_wr, owner_busy;
    logic [31:0]        rdata;
    logic               unused_ok;

    assign bus_sel    = wb_cyc_i & wb_stb_i & (wb_adr_i[31:10] == 22'h1);
    assign bus_acc    = bus_sel & ~wb_ack_o;
    assign bus_wr     = bus_acc & wb_we_i;
    assign ctrl_wr    = bus_wr & (wb_adr_i[11:2] == ADR_CTRL);
    assign wb_stall_o = 1'b0;
    assign owner_busy = mux_sel_o ? dshot_busy_i : serial_busy_i;
    assign unused_ok  = ^{wb_sel_i, wb_dat_i[31:16], wb_adr_i[1:0], TIMEOUT_CYCLES};

    // Register read mux
    always_comb begin
        rdata = '0;
        case (wb_adr_i[11:2])
            ADR_CTRL:   rdata = {31'b0, req_sel};
            ADR_STATUS: rdata = {16'b0, switch_cnt, 5'b0, revert_q, switching_o, mux_sel_o};
            ADR_GUARD:  rdata = {16'b0, guard_cycles};
            default:    rdata = '0;
        endcase
    end

    // Bus handshake and control registers; a bus write wins over FSM-side clears
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            wb_ack_o     <= 1'b0;
            wb_dat_o     <= '0;
            req_sel      <= 1'b0;
            force_q      <= 1'b0;
            guard_cycles <= GUARD_DEFAULT;
        end else begin
            wb_ack_o <= bus_acc;
            wb_dat_o <= (bus_acc & ~wb_we_i) ? rdata : '0;
            if (force_clr)   force_q <= 1'b0;
            if (timeout_hit) req_sel <= 1'b0;
            if (ctrl_wr) begin
                req_sel <= wb_dat_i[0];
                force_q <= wb_dat_i[1];
            end
            if (bus_wr && wb_adr_i[11:2] == ADR_GUARD) guard_cycles <= wb_dat_i[GUARD_W-1:0];
        end
    end

`ifdef SERIAL_DSHOT_ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt;

    assign timeout_hit = (state == S_DSHOT) && !dshot_busy_i && (to_cnt == TIMEOUT_CYCLES - TO_W'(1));

    // Consecutive idle cycles while DSHOT owns the line
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            to_cnt   <= '0;
            revert_q <= 1'b0;
        end else begin
            if (state != S_DSHOT || dshot_busy_i || timeout_hit) to_cnt <= '0;
            else                                                 to_cnt <= to_cnt + TO_W'(1);
            if (ctrl_wr)          revert_q <= 1'b0;
            else if (timeout_hit) revert_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign revert_q    = 1'b0;
`endif

    // State register and registered line outputs
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state       <= S_SERIAL;
            cnt         <= '0;
            target      <= 1'b0;
            mux_sel_o   <= 1'b0;
            line_oe_o   <= 1'b1;
            switching_o <= 1'b0;
            switch_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            target      <= target_nxt;
            mux_sel_o   <= mux_nxt;
            line_oe_o   <= line_oe_nxt;
            switching_o <= switching_nxt;
            if (sw_done) switch_cnt <= switch_cnt + CNT_W'(1);
        end
    end

    // Next-state logic; mux_sel_o doubles as the current owner
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        target_nxt = target;
        mux_nxt    = mux_sel_o;
        sw_done    = 1'b0;
        force_clr  = 1'b0;
        case (state)
            S_SERIAL, S_DSHOT: begin
                if (req_sel != mux_sel_o) begin
                    target_nxt = req_sel;
                    state_nxt  = S_DRAIN;
                end else begin
                    force_clr = 1'b1;
                end
            end
            S_DRAIN: begin
                if (req_sel == mux_sel_o) begin
                    state_nxt = mux_sel_o ? S_DSHOT : S_SERIAL;
                    force_clr = 1'b1;
                end else if (!owner_busy || force_q) begin
                    cnt_nxt   = guard_cycles;
                    state_nxt = S_GUARD;
                    force_clr = 1'b1;
                end
            end
            S_GUARD: begin
                if (cnt == '0) begin
                    mux_nxt   = target;
                    sw_done   = 1'b1;
                    state_nxt = target ? S_DSHOT : S_SERIAL;
                end else begin
                    cnt_nxt = cnt - GUARD_W'(1);
                end
            end
            default: state_nxt = S_SERIAL;
        endcase
    end

    // Line outputs decoded from the upcoming state so they register in step with it
    always_comb begin
        line_oe_nxt   = 1'b1;
        switching_nxt = 1'b0;
        case (state_nxt)
            S_DRAIN: switching_nxt = 1'b1;
            S_GUARD: begin
                switching_nxt = 1'b1;
                line_oe_nxt   = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/wb_serial_dshot_arbiter.md
# wb_serial_dshot_arbiter

Wishbone-controlled sequencer that owns the shared ESC signal line and hands it between the TTL serial (passthrough) engine and the DSHOT engine. A requested owner change is not applied immediately: the block waits for the current owner to go idle, releases the line for a programmable guard time, then switches the output mux. It sits between the Wishbone interconnect and the two line drivers, replacing a bare select register.

## Interface
Parameters:
- GUARD_DEFAULT, 16'd1000: reset value of the guard-time register, in clocks.
- TIMEOUT_CYCLES, 24'd1_000_000: DSHOT inactivity limit for auto-revert (only used with the macro).

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_ni  in  1  synchronous, active-low reset.
- wb_adr_i  in  32  byte address; decode uses [11:2].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects; ignored, all writes are full-word.
- wb_we_i, wb_stb_i, wb_cyc_i  in  1 each  standard Wishbone strobes.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_stall_o  out  1  tied 0.
- serial_busy_i  in  1  serial engine is mid-frame.
- dshot_busy_i  in  1  DSHOT engine is mid-frame.
- mux_sel_o  out  1  active owner: 0 = serial, 1 = DSHOT.
- line_oe_o  out  1  1 = the selected engine drives the pin; 0 = released (external pull-up).
- switching_o  out  1  high in DRAIN and GUARD.

## Operation
- Registers. A register is selected when cyc & stb & adr[11:2] matches its word address.
  - CTRL 0x0400 (RW): bit0 req_sel, bit1 force. force is write-only and reads 0.
  - STATUS 0x0404 (RO): bit0 mux_sel_o, bit1 switching_o, bits[15:8] switch_cnt.
  - GUARD 0x0408 (RW): bits[15:0] guard_cycles.
- Unmapped addresses in the 0x0400–0x07FF window are acked and read 0.
- Addresses outside that window are never acked.
- FSM states: S_SERIAL, S_DSHOT, S_DRAIN, S_GUARD. A target register holds the pending owner.
- S_SERIAL / S_DSHOT: line_oe_o = 1.
  - If req_sel differs from the owner: capture target = req_sel and go to S_DRAIN.
- S_DRAIN: line_oe_o = 1.
  - Exits when the current owner's busy is low, or when force was written with this request. Then load cnt = guard_cycles and go to S_GUARD.
  - If req_sel returns to the current owner while in S_DRAIN: go back to the owner state. No switch occurs and switch_cnt is unchanged.
- S_GUARD: line_oe_o = 0, mux_sel_o unchanged.
  - Each cycle: if cnt == 0, set mux_sel_o = target, increment switch_cnt, and enter the target state. Otherwise decrement cnt.
  - req_sel changes during S_GUARD are ignored until the target state is reached, then re-evaluated normally.
- switch_cnt is 8 bits and wraps 255 → 0.
- Writing GUARD during a switch affects only the next load.

## Timing
- Reset values: mux_sel_o = 0, line_oe_o = 1, switching_o = 0, wb_ack_o = 0, wb_dat_o = 0, req_sel = 0, guard_cycles = GUARD_DEFAULT, switch_cnt = 0, state = S_SERIAL.
- Reset mid-switch aborts to these values in one cycle.
- Bus handshake:
  - wb_ack_o rises the cycle after the select is asserted.
  - It is a single-cycle pulse: ack <= select & ~ack.
  - Write data commits on the ack edge; read data is valid with ack.
- FSM latency, with a write acked at edge N:
  - At edge N+1 the FSM enters S_DRAIN.
  - With busy low, it enters S_GUARD at N+2.
  - The new owner is reached at N+3+guard_cycles.
  - guard_cycles = 0 still gives one released cycle.
- A force write and a req_sel write are the same transaction. force affects only the switch it starts.

## Configuration
- SERIAL_DSHOT_ARB_TIMEOUT_EN defined:
  - In S_DSHOT, a 24-bit counter counts consecutive cycles with dshot_busy_i low. It resets on any dshot_busy_i high.
  - When the count reaches TIMEOUT_CYCLES, req_sel is cleared to 0, which starts a normal switch back to serial.
  - STATUS bit2 is set on auto-revert; it is cleared by any CTRL write.
- Macro undefined:
  - No counter and no auto-revert; STATUS bit2 reads 0.
  - The block stays in S_DSHOT indefinitely.

## Test plan
- Reset: read STATUS → 0x0000_0000. Read GUARD → GUARD_DEFAULT. line_oe_o = 1.
- Write CTRL = 1 with GUARD = 4 and serial_busy_i low → switching_o high for 6 cycles, line_oe_o low for exactly 5, then mux_sel_o = 1 and STATUS = 0x0000_0101.
- Write CTRL = 1 while serial_busy_i is high for 20 cycles → stays in S_DRAIN with line_oe_o = 1 for those 20 cycles, then the guard runs. Repeat with CTRL = 3 → no drain wait.
- Write CTRL = 1, then CTRL = 0 while draining → back to S_SERIAL, mux_sel_o never changes, switch_cnt = 0.
- Perform 256 switches → switch_cnt wraps to 0. Assert wb_rst_ni low during S_GUARD → all outputs take their reset values on the next edge.
- With the macro defined and TIMEOUT_CYCLES = 100: enter DSHOT, hold dshot_busy_i low for 100 cycles → req_sel = 0, switch back to serial, STATUS bit2 = 1.
